keypad_event_ctrl: RTL and testbench
====================================

// Module: keypad_event_ctrl
// PURPOSE
//  Sequencing controller for the keypad scanners (4x4 / 4x3). Generates the scan-step
//  tick, debounces completed button snapshots and converts each debounced change into a
//  press/release event. Events are arbitrated round-robin into a small FIFO and drained
//  by the consumer over a valid/ready interface. Sits between the scanner and host logic.
// PARAMETERS
//  N_KEYS      16    buttons in the snapshot (16 for 4x4, 12 for 4x3)
//  SCAN_DIV    1000  clk cycles per scan step; >=2
//  DEBOUNCE    4     consecutive identical snapshots before acceptance; >=1
//  FIFO_DEPTH  4     event FIFO entries; power of 2
// PORTS
//  clk        in   1       clock
//  rst        in   1       reset, asynchronous, active-high
//  scan_tick  out  1       1-cycle strobe; scanner step enable
//  snap       in   1       1-cycle pulse: buttons holds a new complete snapshot
//  buttons    in   N_KEYS  raw snapshot, bit i = key code i down
//  evt_valid  out  1       FIFO head valid
//  evt_ready  in   1       consumer accepts head
//  evt_press  out  1       1 = press, 0 = release
//  evt_code   out  CW      key index, CW = $clog2(N_KEYS)
//  any_down   out  1       OR of debounced state
// BEHAVIOUR
//  Reset: scan counter 0, scan_tick 0, last/debounced/pending 0, stable_cnt 0, RR ptr 0,
//   FIFO empty, evt_valid 0, evt_press 0, evt_code 0, any_down 0. Reset mid-operation
//   discards pending and queued events; divider restarts from 0.
//  Divider: cnt 0..SCAN_DIV-1, scan_tick=1 for the cycle cnt==SCAN_DIV-1, then wrap.
//  Debounce, on snap only: buttons!=last -> last<=buttons, stable_cnt<=0;
//   else stable_cnt saturates at DEBOUNCE; on the 0->DEBOUNCE-1 crossing to DEBOUNCE
//   (DEBOUNCE==1: first equal snap) debounced<=last. One update per crossing.
//  Change detect, cycle after debounced update: rise=new&~old sets pend_p, fall sets pend_r.
//   Key with pend_p getting fall (or pend_r getting rise) clears both: no event.
//   Hence pend_p[i]&pend_r[i] never both set.
//  FSM: IDLE -> PICK when |(pend_p|pend_r). PICK: lowest index >= ptr (wrapping) with
//   pending bit, latch idx -> PUSH. PUSH: if FIFO !full write {pend_p[idx],idx}, clear
//   that bit, ptr<=idx+1 mod N_KEYS, -> PICK if more pending else IDLE; if full, stay.
//   Pend update same cycle as PUSH clear: clear applies first, new bits OR'd after;
//   a cancel hitting the latched idx aborts the write (-> PICK).
//  Latency: snap (crossing) -> debounced +1 -> pending +2 -> PICK +3 -> write +4 ->
//   evt_valid +5 clk.
//  FIFO: show-ahead; pop when evt_valid&evt_ready; push+pop while full allowed; no
//   events lost on full (backpressure held in pending bits). evt_press/evt_code hold
//   while evt_valid&~evt_ready.
//  any_down is registered |debounced.
// STRUCTURE
//  keypad_pkg: evt_t struct {press, code[3:0]}; KEY_* constants for the 4x4 map
//   (0-9, KEY_A=10, KEY_B=11, KEY_C=12, KEY_D=13, KEY_STAR=14, KEY_HASH=15); FSM enum.
//  Sub-module keypad_evt_fifo (sync FIFO, evt_t width, DEPTH param, full/empty flags).
//  Divider, debounce, pending/arbiter FSM stay in this module.
// TESTING
//  SCAN_DIV=4, 20 cycles -> scan_tick at cycles 3,7,11,15,19 only.
//  DEBOUNCE=4, key 5 set in 4 snaps -> one event press=1 code=5, 5 clk after 4th snap.
//  Key 5 alternates 1/0 every snap, 20 snaps -> no event, any_down stays 0.
//  Keys 3,9,12 pressed same snapshot, ptr=10 -> order 12,3,9.
//  evt_ready=0, 6 keys pressed -> FIFO holds 4, remaining 2 delivered in RR order on drain.
//  rst asserted with 3 events queued -> evt_valid 0 same cycle; no events after release.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared event type, 4x4 key codes and arbiter states for the keypad controller
package keypad_pkg;
  typedef struct packed {
    logic       press;
    logic [3:0] code;
  } evt_t;
  localparam logic [3:0] KEY_0 = 4'd0, KEY_1 = 4'd1, KEY_2 = 4'd2, KEY_3 = 4'd3;
  localparam logic [3:0] KEY_4 = 4'd4, KEY_5 = 4'd5, KEY_6 = 4'd6, KEY_7 = 4'd7;
  localparam logic [3:0] KEY_8 = 4'd8, KEY_9 = 4'd9, KEY_A = 4'd10, KEY_B = 4'd11;
  localparam logic [3:0] KEY_C = 4'd12, KEY_D = 4'd13, KEY_STAR = 4'd14, KEY_HASH = 4'd15;
  typedef enum logic [1:0] {IDLE, PICK, PUSH} st_t;
endpackage

// File: rtl/keypad_evt_fifo.sv
// keypad_evt_fifo: show-ahead synchronous event FIFO, push accepted on a full FIFO when popping
module keypad_evt_fifo
  import keypad_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  evt_t wdata,
  input  logic pop,
  output evt_t rdata,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  evt_t mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata = mem[rp[AW-1:0]];
  // read/write pointers, extra msb separates full from empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (AW+1)'(do_push);
      rp <= rp + (AW+1)'(do_pop);
    end
  end
  // storage needs no reset; outputs are gated by the empty flag upstream
  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/keypad_event_ctrl.sv
// keypad_event_ctrl: scan tick, snapshot debounce and round-robin press/release event queue
module keypad_event_ctrl
  import keypad_pkg::*;
#(
  parameter int N_KEYS = 16,
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int CW = $clog2(N_KEYS)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              scan_tick,
  input  logic              snap,
  input  logic [N_KEYS-1:0] buttons,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic              evt_press,
  output logic [CW-1:0]     evt_code,
  output logic              any_down
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(DEBOUNCE + 1);
  localparam logic [SW-1:0] SAT = SW'(DEBOUNCE);
  // the mismatching snapshot is the first of the run, so acceptance lands one count early
  localparam logic [SW-1:0] ACC = SW'((DEBOUNCE > 1) ? DEBOUNCE - 2 : 0);
  logic [DW-1:0] div;
  logic [SW-1:0] stab;
  logic [N_KEYS-1:0] last, deb, deb_prev, pend_p, pend_r;
  logic [N_KEYS-1:0] pend_any, rise, fall, chg, clr, p, r, cancel, p_nxt, r_nxt;
  logic [CW-1:0] ptr, idx, pick;
  st_t state, nxt;
  logic wr, abort, full, empty;
  evt_t head;
  function automatic logic [CW-1:0] wrap(input int v);
    return CW'(v % N_KEYS);
  endfunction
  assign scan_tick = div == DW'(SCAN_DIV - 1);
  assign pend_any = pend_p | pend_r;
  assign evt_valid = ~empty;
  assign evt_press = evt_valid & head.press;
  assign evt_code = evt_valid ? head.code[CW-1:0] : '0;
  // scan-step divider
  always_ff @(posedge clk or posedge rst) begin
    if (rst) div <= '0;
    else div <= scan_tick ? '0 : div + 1'b1;
  end
  // debounce: restart on any difference, accept once per stable run
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= '0;
      deb <= '0;
      stab <= '0;
    end else if (snap) begin
      if (buttons != last) begin
        last <= buttons;
        stab <= '0;
      end else if (stab != SAT) begin
        stab <= stab + 1'b1;
        if (stab == ACC) deb <= last;
      end
    end
  end
  // lowest pending key at or after ptr, wrapping
  always_comb begin
    pick = '0;
    for (int k = N_KEYS - 1; k >= 0; k--)
      if (pend_any[wrap(int'(ptr) + k)]) pick = wrap(int'(ptr) + k);
  end
  // pending update (push clear first, then new edges, opposite edges cancel) and next state
  always_comb begin
    rise = deb & ~deb_prev;
    fall = ~deb & deb_prev;
    chg = rise | fall;
    abort = chg[idx] | ~pend_any[idx];
    wr = (state == PUSH) & ~abort & ~full;
    clr = wr ? (N_KEYS'(1) << idx) : '0;
    p = pend_p & ~clr;
    r = pend_r & ~clr;
    cancel = (p & fall) | (r & rise);
    p_nxt = (p | rise) & ~cancel;
    r_nxt = (r | fall) & ~cancel;
    nxt = (state == IDLE) ? (|pend_any ? PICK : IDLE) :
          (state == PICK) ? (|pend_any ? PUSH : IDLE) :
          abort ? PICK : full ? PUSH : |(p_nxt | r_nxt) ? PICK : IDLE;
  end
  // arbiter state, pending bits, round-robin pointer and registered status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      deb_prev <= '0;
      pend_p <= '0;
      pend_r <= '0;
      idx <= '0;
      ptr <= '0;
      any_down <= 1'b0;
    end else begin
      state <= nxt;
      deb_prev <= deb;
      pend_p <= p_nxt;
      pend_r <= r_nxt;
      any_down <= |deb;
      if (state == PICK) idx <= pick;
      if (wr) ptr <= (idx == CW'(N_KEYS - 1)) ? '0 : idx + 1'b1;
    end
  end
  keypad_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(wr),
    .wdata({pend_p[idx], 4'(idx)}),
    .pop(evt_valid & evt_ready),
    .rdata(head),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_keypad_event_ctrl.sv
// tb_keypad_event_ctrl: directed and random checks against a snapshot-level event model
module tb_keypad_event_ctrl;
  import keypad_pkg::*;
  localparam int N = 16;
  localparam int D = 4;
  logic clk = 0, rst = 1, snap = 0, evt_ready = 0;
  logic [N-1:0] buttons = '0;
  logic scan_tick, evt_valid, evt_press, any_down;
  logic [3:0] evt_code;
  int n_chk = 0, n_err = 0, rdy_mode = 0;
  int exp_q[$], got_q[$];
  logic [N-1:0] m_last, m_deb;
  int m_run, m_ptr;
  always #5 clk = ~clk;
  keypad_event_ctrl #(.N_KEYS(N), .SCAN_DIV(4), .DEBOUNCE(D), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .scan_tick(scan_tick), .snap(snap), .buttons(buttons),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_press(evt_press),
    .evt_code(evt_code), .any_down(any_down)
  );
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_last = '0;
    m_deb = '0;
    m_run = 1;
    m_ptr = 0;
    exp_q.delete();
  endtask
  // a key changes once DEBOUNCE identical snapshots in a row are seen; changes leave in
  // cyclic key order starting at the key after the last one reported
  task automatic model_snap(input logic [N-1:0] b);
    logic [N-1:0] c;
    if (b == m_last) m_run++;
    else begin
      m_last = b;
      m_run = 1;
    end
    if (m_run == D) begin
      c = b ^ m_deb;
      for (int k = 0, s = m_ptr; k < N; k++) begin
        int j = (s + k) % N;
        if (c[j]) begin
          exp_q.push_back(int'(b[j]) * 16 + j);
          m_ptr = (j + 1) % N;
        end
      end
      m_deb = b;
    end
  endtask
  task automatic tick(input bit s, input logic [N-1:0] b);
    int g;
    @(negedge clk);
    snap = s;
    buttons = b;
    evt_ready = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    if (s) model_snap(b);
    #1;
    if (!rst && evt_valid && evt_ready) begin
      g = int'(evt_press) * 16 + int'(evt_code);
      got_q.push_back(g);
      if (exp_q.size() == 0) check("evt_unexpected", g, -1);
      else check("evt_data", g, exp_q.pop_front());
    end
  endtask
  task automatic press(input logic [N-1:0] b);
    repeat (D) tick(1, b);
  endtask
  task automatic drain();
    int n = 0;
    rdy_mode = 2;
    while (exp_q.size() != 0 && n < 400) begin
      tick(0, buttons);
      n++;
    end
    check("drain_left", exp_q.size(), 0);
    rdy_mode = 1;
    repeat (8) tick(0, buttons);
    check("idle_valid", int'(evt_valid), 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end
  initial begin
    logic [N-1:0] b, t;
    int rr_exp[3] = '{16 + 12, 16 + 3, 16 + 9};
    int bp_exp[6] = '{16 + 11, 16 + 13, 16 + 14, 16 + 15, 16 + 1, 16 + 5};
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check("rst_scan_tick", int'(scan_tick), 0);
    check("rst_evt_valid", int'(evt_valid), 0);
    check("rst_evt_press", int'(evt_press), 0);
    check("rst_evt_code", int'(evt_code), 0);
    check("rst_any_down", int'(any_down), 0);
    rst = 0;
    #1;
    check("scan_tick", int'(scan_tick), 0);
    for (int k = 1; k < 20; k++) begin
      tick(0, '0);
      check("scan_tick", int'(scan_tick), int'(k % 4 == 3));
    end
    press(16'h0020);
    repeat (4) tick(0, buttons);
    check("lat_valid_early", int'(evt_valid), 0);
    tick(0, buttons);
    check("lat_valid", int'(evt_valid), 1);
    check("lat_press", int'(evt_press), 1);
    check("lat_code", int'(evt_code), 5);
    drain();
    check("any_down_k5", int'(any_down), 1);
    press('0);
    drain();
    for (int i = 0; i < 20; i++) begin
      tick(1, (i % 2 == 0) ? 16'h0020 : 16'h0000);
      repeat (2) tick(0, buttons);
      check("alt_any_down", int'(any_down), 0);
    end
    drain();
    press(16'h0200);
    drain();
    press('0);
    drain();
    got_q.delete();
    press(16'h1208);
    drain();
    for (int i = 0; i < 3; i++) check("rr_order", (i < got_q.size()) ? got_q[i] : -1, rr_exp[i]);
    press('0);
    drain();
    got_q.delete();
    rdy_mode = 0;
    press(16'hE822);
    repeat (30) tick(0, buttons);
    check("bp_valid", int'(evt_valid), 1);
    check("bp_head", int'(evt_code), 11);
    drain();
    for (int i = 0; i < 6; i++) check("bp_order", (i < got_q.size()) ? got_q[i] : -1, bp_exp[i]);
    for (int rnd = 0; rnd < 15; rnd++) begin
      rdy_mode = 2;
      repeat ($urandom_range(0, 3)) begin
        b = N'($urandom);
        while (b == m_last) b = N'($urandom);
        tick(1, b);
        repeat ($urandom_range(0, 2)) tick(0, b);
      end
      t = N'($urandom);
      repeat (D) begin
        tick(1, t);
        repeat ($urandom_range(0, 2)) tick(0, t);
      end
      drain();
      check("rnd_any_down", int'(any_down), int'(|m_deb));
    end
    rdy_mode = 0;
    b = m_deb ^ 16'h0007;
    press(b);
    repeat (15) tick(0, b);
    check("pre_rst_valid", int'(evt_valid), 1);
    @(negedge clk);
    rst = 1;
    #1;
    check("mid_rst_valid", int'(evt_valid), 0);
    check("mid_rst_any_down", int'(any_down), 0);
    model_reset();
    @(negedge clk);
    rst = 0;
    rdy_mode = 1;
    repeat (20) tick(0, b);
    check("post_rst_valid", int'(evt_valid), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
